led_indicator: RTL and testbench

LED_INDICATOR -- requirements
Module: led_indicator

---
 rtl/led_ind_pkg.sv | 22 ++
 rtl/tick_gen.sv | 27 ++
 rtl/led_indicator.sv | 135 +++++++++++++
 tb/tb_led_indicator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/led_ind_pkg.sv
// Shared types and sizing helper for the LED indicator block.
package led_ind_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    FLASH = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON_PH  = 2'd1,
    GAP_PH = 2'd2
  } state_t;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: pulses tick every PRESCALE cycles, restartable from 0.
module tick_gen
  import led_ind_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = cnt_width(PRESCALE);

  logic [W-1:0] count_reg;

  assign tick = (count_reg == W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset || restart || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_indicator.sv
// LED driver with steady/blink/queued-flash modes built on a tick-based phase FSM.
module led_indicator
  import led_ind_pkg::*;
#(
  parameter int PRESCALE  = 50000,
  parameter int ON_TICKS  = 100,
  parameter int OFF_TICKS = 100,
  parameter int MAX_PEND  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       event_i,
  input  logic [1:0] mode,
  input  logic       clr_ovf,
  output logic       led,
  output logic       busy,
  output logic [2:0] pend_cnt,
  output logic       overflow
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PH_W      = cnt_width(MAX_TICKS);
  localparam int PEND_W    = cnt_width(MAX_PEND + 1);

  state_t            state_reg, state_next;
  logic [PH_W-1:0]   ph_reg, ph_next;
  logic [PEND_W-1:0] pend_reg, pend_next;
  logic              ovf_reg, ovf_next;
  logic              led_reg, led_next;
  logic [1:0]        mode_prev_reg;
  logic              restart, deq, tick, ev, mode_chg;
  mode_t             mode_cur;

  assign mode_cur = mode_t'(mode);
  assign mode_chg = (mode != mode_prev_reg);
  assign ev       = event_i && (mode_cur == FLASH);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ph_reg        <= '0;
      pend_reg      <= '0;
      ovf_reg       <= 1'b0;
      led_reg       <= 1'b0;
      mode_prev_reg <= OFF;
    end else begin
      state_reg     <= state_next;
      ph_reg        <= ph_next;
      pend_reg      <= pend_next;
      ovf_reg       <= ovf_next;
      led_reg       <= led_next;
      mode_prev_reg <= mode;
    end
  end

  // Phase sequencing; a mode change aborts any running phase.
  always_comb begin
    state_next = state_reg;
    ph_next    = ph_reg;
    restart    = 1'b0;
    deq        = 1'b0;
    if (mode_chg && (state_reg != IDLE)) begin
      state_next = IDLE;
      ph_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if ((mode_cur == BLINK) || ((mode_cur == FLASH) && (pend_reg != '0))) begin
            state_next = ON_PH;
            ph_next    = '0;
            restart    = 1'b1;
            deq        = (mode_cur == FLASH);
          end
        end
        ON_PH: begin
          if (tick) begin
            if (ph_reg == PH_W'(ON_TICKS - 1)) begin
              state_next = GAP_PH;
              ph_next    = '0;
              restart    = 1'b1;
            end else begin
              ph_next = ph_reg + 1'b1;
            end
          end
        end
        GAP_PH: begin
          if (tick) begin
            if (ph_reg == PH_W'(OFF_TICKS - 1)) begin
              state_next = IDLE;
              ph_next    = '0;
            end else begin
              ph_next = ph_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          ph_next    = '0;
        end
      endcase
    end
  end

  // Event queue: a coincident enqueue and dequeue cancel out.
  always_comb begin
    pend_next = pend_reg;
    ovf_next  = clr_ovf ? 1'b0 : ovf_reg;
    if (ev && !deq) begin
      if (pend_reg == PEND_W'(MAX_PEND)) begin
        ovf_next = 1'b1;
      end else begin
        pend_next = pend_reg + 1'b1;
      end
    end else if (!ev && deq) begin
      pend_next = pend_reg - 1'b1;
    end
  end

  assign led_next = (state_next == ON_PH) || (mode_cur == ON);

  assign led      = led_reg;
  assign busy     = (state_reg != IDLE);
  assign pend_cnt = 3'(pend_reg);
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_led_indicator.sv
// Directed bench for led_indicator with short phases (PRESCALE=4, 3 on / 2 off ticks, 3 pending).
module tb_led_indicator;

  localparam int P  = 4;
  localparam int NT = 3;
  localparam int FT = 2;
  localparam int MP = 3;
  localparam int ON_LEN  = P * NT;
  localparam int GAP_LEN = P * FT;

  logic       clk = 1'b0;
  logic       reset;
  logic       event_i;
  logic [1:0] mode;
  logic       clr_ovf;
  logic       led;
  logic       busy;
  logic [2:0] pend_cnt;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  led_indicator #(
    .PRESCALE (P),
    .ON_TICKS (NT),
    .OFF_TICKS(FT),
    .MAX_PEND (MP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .event_i (event_i),
    .mode    (mode),
    .clr_ovf (clr_ovf),
    .led     (led),
    .busy    (busy),
    .pend_cnt(pend_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int   rises;
    int   run;
    logic prev;

    reset = 1'b1; mode = 2'd3; event_i = 1'b0; clr_ovf = 1'b0;
    cyc(2);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    cyc(3);
    chk("idle_busy", busy, 0);

    // Single flash: event at t, pend at t+1, led at t+2 for 12, gap 8, idle after.
    event_i = 1'b1; cyc; event_i = 1'b0;
    chk("lat_pend", pend_cnt, 1);
    chk("lat_led0", led, 0);
    cyc;
    chk("lat_led1", led, 1);
    chk("lat_busy", busy, 1);
    chk("lat_deq", pend_cnt, 0);
    for (int i = 1; i < ON_LEN; i++) begin cyc; chk("on_led", led, 1); end
    for (int i = 0; i < GAP_LEN; i++) begin cyc; chk("gap_led", led, 0); chk("gap_busy", busy, 1); end
    cyc;
    chk("end_busy", busy, 0);

    // Five events during a running flash: queue saturates at 3 and overflows.
    event_i = 1'b1; cyc; event_i = 1'b0; cyc;
    chk("burst_on", led, 1);
    event_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc;
      chk("burst_pend", pend_cnt, (i < MP) ? i : MP);
      chk("burst_ovf", overflow, (i > MP) ? 1 : 0);
    end
    event_i = 1'b0;
    rises = 0; run = 1; prev = led;
    for (int i = 0; i < 100; i++) begin
      cyc;
      if (led === prev) begin
        run++;
      end else begin
        if (led === 1'b1) begin
          rises++;
          chk("burst_low_len", run, GAP_LEN + 1);
        end else if (rises > 0) begin
          chk("burst_high_len", run, ON_LEN);
        end
        prev = led;
        run  = 1;
      end
    end
    chk("burst_pulses", rises, MP);
    chk("burst_drained", pend_cnt, 0);
    chk("burst_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1; cyc; clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);

    // BLINK with events held: 12 on / 8 gap / 1 idle, queue untouched.
    mode = 2'd2; event_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc;
      chk("blink_led", led, ((i % (ON_LEN + GAP_LEN + 1)) < ON_LEN) ? 1 : 0);
      chk("blink_pend", pend_cnt, 0);
    end
    mode = 2'd0; event_i = 1'b0; cyc;
    chk("blink_abort_led", led, 0);
    chk("blink_abort_busy", busy, 0);

    // Steady ON and back to OFF.
    mode = 2'd1; cyc;
    chk("on_mode_led", led, 1);
    chk("on_mode_busy", busy, 0);
    mode = 2'd0; cyc;
    chk("off_mode_led", led, 0);

    // Abort a flash mid-ON with two queued; queue is retained and replays.
    mode = 2'd3; event_i = 1'b1; cyc; event_i = 1'b0; cyc;
    chk("abort_on", led, 1);
    event_i = 1'b1; cyc(2); event_i = 1'b0;
    chk("abort_pend", pend_cnt, 2);
    mode = 2'd0; cyc;
    chk("abort_led", led, 0);
    chk("abort_busy", busy, 0);
    chk("abort_keep", pend_cnt, 2);
    cyc(5);
    chk("abort_hold_led", led, 0);
    chk("abort_hold_pend", pend_cnt, 2);
    mode = 2'd3; cyc;
    chk("replay_led", led, 1);
    chk("replay_pend", pend_cnt, 1);
    event_i = 1'b1; cyc; event_i = 1'b0;
    chk("replay_pend2", pend_cnt, 2);

    // Reset mid-gap with two pending clears everything.
    cyc(13);
    chk("pre_rst_gap_led", led, 0);
    chk("pre_rst_gap_busy", busy, 1);
    reset = 1'b1; cyc; reset = 1'b0;
    chk("mid_rst_led", led, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pend", pend_cnt, 0);
    chk("mid_rst_ovf", overflow, 0);
    for (int i = 0; i < 30; i++) begin cyc; chk("post_rst_quiet", led, 0); end
    event_i = 1'b1; cyc; event_i = 1'b0; cyc;
    chk("post_rst_flash", led, 1);

    // Enqueue coincident with dequeue at full, then clr_ovf vs overflowing event.
    event_i = 1'b1; cyc(3); event_i = 1'b0;
    chk("full_pend", pend_cnt, 3);
    mode = 2'd0; cyc;
    chk("full_idle", busy, 0);
    chk("full_keep", pend_cnt, 3);
    mode = 2'd3; event_i = 1'b1; cyc;
    chk("coin_pend", pend_cnt, 3);
    chk("coin_ovf", overflow, 0);
    chk("coin_led", led, 1);
    clr_ovf = 1'b1; cyc;
    chk("set_wins_ovf", overflow, 1);
    chk("set_wins_pend", pend_cnt, 3);
    event_i = 1'b0; cyc; clr_ovf = 1'b0;
    chk("clr_only_ovf", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
